// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern-detector front end.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Patterns are carried in a fixed 8-bit container; only the low PAT_LEN bits are used.
  localparam int                       MAX_PAT_LEN = 8;
  localparam logic [MAX_PAT_LEN-1:0]   DEF_PATTERN = 8'b0001_1001;
  localparam int                       DEF_PAT_LEN = 5;

endpackage

// File: rtl/seq_det_ctrl_pattern_det.sv
// Overlapping Mealy detector: hit is asserted combinationally on the step that
// completes PATTERN, judged against the last PAT_LEN-1 stepped bits.
module pattern_det
  import seq_det_pkg::*;
#(
  parameter logic [MAX_PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                     PAT_LEN = DEF_PAT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  input  logic bit_in,
  output logic hit
);

  localparam int                   HIST_W   = PAT_LEN - 1;
  localparam int                   FILL_W   = $clog2(PAT_LEN);
  localparam logic [PAT_LEN-1:0]   PAT      = PATTERN[PAT_LEN-1:0];
  localparam logic [FILL_W-1:0]    FULL_CNT = FILL_W'(HIST_W);

  logic [HIST_W-1:0]  hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               full;

  // The fill count stops a cleared (all-zero) history from matching a
  // pattern that happens to begin with zeros.
  assign window = {hist, bit_in};
  assign full   = (fill == FULL_CNT);
  assign hit    = step & full & (window == PAT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (step) begin
      hist <= window[HIST_W-1:0];
      if (!full) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit front end for the serial pattern detector: valid/ready intake,
// MSB-first serialisation, saturating match counter and sticky threshold irq.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int                     WIDTH   = 8,
  parameter int                     CNT_W   = 8,
  parameter logic [MAX_PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                     PAT_LEN = DEF_PAT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr_cnt,
  output logic             busy,
  output logic             det_bit,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] bit_idx;
  logic             step;
  logic             last_bit;
  logic             accept;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On the last bit the intake reopens so the next word follows with no bubble.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    step      = 1'b0;
    last_bit  = 1'b0;
    det_bit   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        s_ready = en & ~flush & ~rst;
        if (s_valid && s_ready) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        det_bit  = shreg[WIDTH-1];
        step     = en & ~flush;
        last_bit = step & (bit_idx == '0);
        s_ready  = last_bit & ~rst;
        if (last_bit && !s_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shreg   <= s_data;
      bit_idx <= LAST_IDX;
    end else if (step) begin
      shreg   <= {shreg[WIDTH-2:0], 1'b0};
      bit_idx <= bit_idx - 1'b1;
    end
  end

  pattern_det #(
    .PATTERN (PATTERN),
    .PAT_LEN (PAT_LEN)
  ) u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .step   (step),
    .bit_in (det_bit),
    .hit    (hit)
  );

  // clr_cnt wins over a coincident hit; the match pulse itself is unaffected.
  assign cnt_nxt = clr_cnt ? '0 : (hit ? sat_inc(match_cnt) : match_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      match     <= hit;
      match_cnt <= cnt_nxt;
      if (clr_cnt)
        irq <= 1'b0;
      else if (hit && (thresh != '0) && (cnt_nxt >= thresh))
        irq <= 1'b1;
    end
  end

endmodule
